// File: rtl/tuser_tag_scheduler_pkg.sv
// Shared types for the TUSER tag scheduler: FSM state encoding.
package tuser_tag_scheduler_pkg;

    typedef enum logic [1:0] {
        StLoad   = 2'd0,
        StArmed  = 2'd1,
        StPacket = 2'd2
    } sched_state_e;

endpackage

// File: rtl/tuser_tag_scheduler_tag_fifo.sv
// Synchronous tag FIFO; head is read combinationally from storage, no write-to-read bypass.
module tuser_tag_scheduler_tag_fifo #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign full      = (r_count == (AW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign level     = r_count;
    assign pop_data  = r_mem[r_rd_ptr];
    assign w_push_ok = push & ~full;
    assign w_pop_ok  = pop & ~empty;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push_ok && !w_pop_ok)      r_count <= r_count + 1'b1;
            else if (!w_push_ok && w_pop_ok) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok && !clear) r_mem[r_wr_ptr] <= push_data;
    end

endmodule

// File: rtl/tuser_tag_scheduler.sv
// Round-robin tag collection, tag queue and per-packet load sequencing for the TUSER injector.
module tuser_tag_scheduler
    import tuser_tag_scheduler_pkg::*;
#(
    parameter int unsigned USER_WIDTH = 4,
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          soft_clear,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*USER_WIDTH-1:0] req_user,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          mon_tvalid,
    input  logic                          mon_tready,
    input  logic                          mon_tlast,
    output logic [USER_WIDTH-1:0]         next_user,
    output logic                          next_user_write_enable,
    output logic [$clog2(FIFO_DEPTH):0]   tag_level,
    output logic                          underrun,
    output logic [31:0]                   packet_count
);

    localparam int unsigned RrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    sched_state_e          r_state;
    sched_state_e          w_state_d;
    logic [RrW-1:0]        r_rr;
    logic [RrW-1:0]        w_cand;
    logic [RrW-1:0]        w_grant_idx;
    logic                  w_grant_any;
    logic [USER_WIDTH-1:0] w_push_data;
    logic [USER_WIDTH-1:0] w_head;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_beat;
    logic                  w_first;
    logic                  w_pop;
    logic                  w_underrun;
    logic [USER_WIDTH-1:0] r_next_user;
    logic                  r_we;
    logic                  r_underrun;
    logic [31:0]           r_pkt;

    assign w_beat  = mon_tvalid & mon_tready;
    assign w_first = w_beat & (r_state != StPacket) & ~soft_clear;

    // Search starts at the rr pointer and wraps; full queue or clear blocks every grant.
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        w_cand      = '0;
        if (!w_full && !soft_clear) begin
            for (int unsigned off = 0; off < NUM_REQ; off++) begin
                w_cand = RrW'((32'(r_rr) + off) % NUM_REQ);
                if (!w_grant_any && req_valid[w_cand]) begin
                    w_grant_any = 1'b1;
                    w_grant_idx = w_cand;
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (w_grant_any && resetn) req_ready[w_grant_idx] = 1'b1;
    end

    assign w_push_data = req_user[32'(w_grant_idx)*USER_WIDTH +: USER_WIDTH];

    tuser_tag_scheduler_tag_fifo #(
        .WIDTH (USER_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (soft_clear),
        .push      (w_grant_any),
        .push_data (w_push_data),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .level     (tag_level)
    );

    // A beat in StLoad always wins over a queued tag: the injector would see it too late.
    always_comb begin
        w_state_d  = r_state;
        w_pop      = 1'b0;
        w_underrun = 1'b0;
        if (soft_clear) begin
            w_state_d = StLoad;
        end else begin
            unique case (r_state)
                StLoad: begin
                    if (w_beat) begin
                        w_underrun = 1'b1;
                        w_state_d  = mon_tlast ? StLoad : StPacket;
                    end else if (!w_empty) begin
                        w_pop     = 1'b1;
                        w_state_d = StArmed;
                    end
                end
                StArmed: begin
                    if (w_beat) w_state_d = mon_tlast ? StLoad : StPacket;
                end
                StPacket: begin
                    if (w_beat && mon_tlast) w_state_d = StLoad;
                end
                default: w_state_d = StLoad;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= StLoad;
            r_rr        <= '0;
            r_next_user <= '0;
            r_we        <= 1'b0;
            r_underrun  <= 1'b0;
            r_pkt       <= '0;
        end else begin
            r_state    <= w_state_d;
            r_we       <= w_pop;
            r_underrun <= w_underrun;
            if (w_pop)   r_next_user <= w_head;
            if (w_first) r_pkt <= r_pkt + 32'd1;
            if (w_grant_any) begin
                r_rr <= (w_grant_idx == RrW'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
            end
        end
    end

    assign next_user              = r_next_user;
    assign next_user_write_enable = r_we;
    assign underrun               = r_underrun;
    assign packet_count           = r_pkt;

endmodule

// File: tb/tb_tuser_tag_scheduler.sv
// Directed bench for tuser_tag_scheduler: reset, loading, round-robin, underrun, clear.
module tb_tuser_tag_scheduler;

    logic       clk = 1'b0;
    logic       resetn;
    logic       soft_clear;
    logic [1:0] req_valid;
    logic [7:0] req_user;
    logic [1:0] req_ready;
    logic       mon_tvalid;
    logic       mon_tready;
    logic       mon_tlast;
    logic [3:0] next_user;
    logic       next_user_write_enable;
    logic [2:0] tag_level;
    logic       underrun;
    logic [31:0] packet_count;

    int n_tests = 0;
    int n_fail  = 0;
    int n_under = 0;
    int exp_pkt = 0;
    int u_snap;
    int l_snap;
    logic [3:0] q_load[$];
    logic [3:0] q_acc[$];

    tuser_tag_scheduler #(
        .USER_WIDTH (4),
        .NUM_REQ    (2),
        .FIFO_DEPTH (4)
    ) dut (
        .clk                    (clk),
        .resetn                 (resetn),
        .soft_clear             (soft_clear),
        .req_valid              (req_valid),
        .req_user               (req_user),
        .req_ready              (req_ready),
        .mon_tvalid             (mon_tvalid),
        .mon_tready             (mon_tready),
        .mon_tlast              (mon_tlast),
        .next_user              (next_user),
        .next_user_write_enable (next_user_write_enable),
        .tag_level              (tag_level),
        .underrun               (underrun),
        .packet_count           (packet_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog");
    end

    // Record strobes, underrun pulses and accepted requests mid-cycle.
    always @(negedge clk) begin
        if (resetn) begin
            if (next_user_write_enable) q_load.push_back(next_user);
            if (underrun) n_under++;
            if (|(req_valid & req_ready)) q_acc.push_back(req_ready[1] ? req_user[7:4] : req_user[3:0]);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_tag(input int req, input logic [3:0] tag);
        if (req == 0) req_user[3:0] = tag;
        else          req_user[7:4] = tag;
        req_valid = (req == 0) ? 2'b01 : 2'b10;
        step(1);
        req_valid = 2'b00;
    endtask

    task automatic wait_load(input int n);
        int c = 0;
        while (q_load.size() < n && c < 20) begin
            step(1);
            c++;
        end
        check("load_wait", q_load.size(), n);
    endtask

    task automatic send_packet(input int n, input bit bp);
        int beats = 0;
        int cyc   = 0;
        mon_tvalid = 1'b1;
        while (beats < n && cyc < 100) begin
            mon_tready = bp ? cyc[0] : 1'b1;
            mon_tlast  = (beats == n - 1);
            if (mon_tready) beats++;
            step(1);
            cyc++;
        end
        mon_tvalid = 1'b0;
        mon_tready = 1'b0;
        mon_tlast  = 1'b0;
        if (cyc >= 100) check("pkt_timeout", cyc, 0);
        exp_pkt++;
    endtask

    initial begin
        resetn = 1'b0; soft_clear = 1'b0; req_valid = 2'b11; req_user = 8'h21;
        mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tlast = 1'b0;
        step(2);
        check("rst_ready", req_ready, 0);
        check("rst_user", next_user, 0);
        check("rst_we", next_user_write_enable, 0);
        check("rst_under", underrun, 0);
        check("rst_pkt", packet_count, 0);
        check("rst_level", tag_level, 0);
        req_valid = 2'b00;
        step(1);
        resetn = 1'b1;
        step(2);
        check("rel_we", next_user_write_enable, 0);

        // T2 basic load then 3-beat packet
        req_user[3:0] = 4'hA; req_valid = 2'b01;
        #1;
        check("t2_ready", req_ready, 2'b01);
        step(1);
        req_valid = 2'b00;
        check("t2_level1", tag_level, 1);
        step(1);
        check("t2_we", next_user_write_enable, 1);
        check("t2_user", next_user, 4'hA);
        check("t2_level0", tag_level, 0);
        step(1);
        check("t2_we_off", next_user_write_enable, 0);
        send_packet(3, 1'b0);
        check("t2_pkt", packet_count, exp_pkt);
        check("t2_under", n_under, 0);
        check("t2_nload", q_load.size(), 1);
        check("t2_tag", q_load[0], 4'hA);

        // T1 async reset mid-traffic
        mon_tvalid = 1'b1; mon_tready = 1'b1; req_valid = 2'b11;
        step(1);
        resetn = 1'b0;
        #2;
        check("t1_ready", req_ready, 0);
        check("t1_user", next_user, 0);
        check("t1_pkt", packet_count, 0);
        check("t1_level", tag_level, 0);
        mon_tvalid = 1'b0; mon_tready = 1'b0; req_valid = 2'b00;
        step(1);
        resetn = 1'b1;
        exp_pkt = 0; n_under = 0;
        q_load.delete(); q_acc.delete();
        step(2);
        check("t1_we", next_user_write_enable, 0);

        // T3 round-robin with both requesters held valid until full
        req_user = 8'h21; req_valid = 2'b11;
        step(8);
        check("t3_level", tag_level, 4);
        check("t3_ready", req_ready, 0);
        check("t3_user", next_user, 1);
        req_valid = 2'b00;
        check("t3_nacc", q_acc.size(), 5);
        for (int i = 0; i < 5; i++) check("t3_acc", q_acc[i], (i % 2 == 0) ? 1 : 2);
        for (int i = 0; i < 5; i++) begin
            send_packet(1, 1'b0);
            step(3);
        end
        check("t3_nload", q_load.size(), 5);
        for (int i = 0; i < 5; i++) check("t3_load", q_load[i], (i % 2 == 0) ? 1 : 2);
        check("t3_under", n_under, 0);
        check("t3_pkt", packet_count, exp_pkt);
        check("t3_empty", tag_level, 0);

        // T4 underrun on empty queue
        u_snap = n_under;
        send_packet(1, 1'b0);
        check("t4_pulse", underrun, 1);
        check("t4_user", next_user, 1);
        check("t4_pkt", packet_count, exp_pkt);
        step(1);
        check("t4_pulse_off", underrun, 0);
        check("t4_nunder", n_under, u_snap + 1);
        push_tag(1, 4'h7);
        wait_load(6);
        check("t4_reload", next_user, 4'h7);
        send_packet(1, 1'b0);
        step(1);

        // T5 first beat collides with a queued tag in StLoad
        u_snap = n_under;
        l_snap = q_load.size();
        push_tag(0, 4'h5);
        send_packet(2, 1'b0);
        check("t5_under", n_under, u_snap + 1);
        check("t5_kept", tag_level, 1);
        check("t5_noload", q_load.size(), l_snap);
        wait_load(l_snap + 1);
        check("t5_tag", q_load[l_snap], 4'h5);
        step(1);
        send_packet(1, 1'b0);
        step(1);
        check("t5_no_under", n_under, u_snap + 1);
        check("t5_pkt", packet_count, exp_pkt);

        // T6 backpressure over 10 packets
        q_load.delete();
        u_snap = n_under;
        for (int i = 0; i < 10; i++) begin
            push_tag(1, 4'(i));
            wait_load(i + 1);
            step(1);
            send_packet(2, 1'b1);
        end
        for (int i = 0; i < 10; i++) check("t6_order", q_load[i], i);
        check("t6_under", n_under, u_snap);
        check("t6_pkt", packet_count, exp_pkt);

        // soft_clear with three queued tags while armed
        push_tag(0, 4'h3);
        wait_load(11);
        req_user[3:0] = 4'hC; req_valid = 2'b01;
        step(3);
        req_valid = 2'b00;
        check("t6_level3", tag_level, 3);
        soft_clear = 1'b1;
        #1;
        check("t6_clr_ready", req_ready, 0);
        step(1);
        soft_clear = 1'b0;
        check("t6_clr_level", tag_level, 0);
        step(3);
        check("t6_clr_nostrobe", q_load.size(), 11);
        push_tag(1, 4'h9);
        wait_load(12);
        check("t6_after_clr", next_user, 4'h9);
        check("t6_pkt_kept", packet_count, exp_pkt);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
